// File: rtl/cop_mul_responder.sv
// Coprocessor-side responder for the CPU coprocessor port.
// Holds a general register file and a small control bank. It answers S-stage reads one cycle
// later and accepts W-stage write-backs. A CMD write launches an iterative 32x32 shift-add
// multiply, and the active-low CONDINN line reports completion.
// Optional feature: define COP_SIGNED_MUL_EN to honour CMD bit1 (two's-complement multiply).
// All state uses a synchronous active-low reset (RESET_D1_R_N).

module cop_mul_responder #(
  parameter int unsigned NGEN     = 32,  // power of two, at most 32
  parameter int unsigned MUL_ITER = 32   // must be 32: one operand bit per cycle
) (
  input  logic        SYSCLK,
  input  logic        RESET_D1_R_N,
  input  logic        RHOLD,
  input  logic [4:0]  CRDADDR,
  input  logic        CRDGEN,
  input  logic        CRDCON,
  output logic [31:0] CRDDATA,
  input  logic [4:0]  CWRADDR_R,
  input  logic        CWRGEN_R,
  input  logic        CWRCON_R,
  input  logic [31:0] CWRDATA_R,
  output logic        CONDINN,
  output logic        BUSY
);

  localparam int unsigned GenAw = (NGEN > 1) ? $clog2(NGEN) : 1;

  // Control register map
  localparam logic [4:0] CStatus = 5'd0;
  localparam logic [4:0] CCmd    = 5'd1;
  localparam logic [4:0] COpa    = 5'd2;
  localparam logic [4:0] COpb    = 5'd3;
  localparam logic [4:0] CRlo    = 5'd4;
  localparam logic [4:0] CRhi    = 5'd5;

  // Multiplier sequencer states
  localparam logic StIdle = 1'b0;
  localparam logic StRun  = 1'b1;

  localparam logic [4:0] LastIter = 5'(MUL_ITER - 1);

  // ---------------------------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------------------------
  logic [31:0] gen_q [NGEN];
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] rlo_q, rlo_d;
  logic [31:0] rhi_q, rhi_d;
  logic        st_q, st_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] mcand_q, mcand_d;   // private multiplicand copy
  logic [31:0] mplier_q, mplier_d; // private multiplier copy, consumed LSB first
  logic [63:0] acc_q, acc_d;
  logic        neg_q, neg_d;       // negate the result at completion

  // ---------------------------------------------------------------------------------------------
  // Write decode
  // ---------------------------------------------------------------------------------------------
  logic              busy;
  logic              wr_in_rng, rd_in_rng;
  logic [GenAw-1:0]  wr_idx, rd_idx;
  logic              gen_wr, con_wr;
  logic              wr_status, wr_cmd, wr_opa, wr_opb;
  logic              start_req;
  logic              signed_sel;

  assign busy      = (st_q == StRun);
  assign wr_in_rng = ({27'd0, CWRADDR_R} < NGEN);
  assign rd_in_rng = ({27'd0, CRDADDR} < NGEN);
  assign wr_idx    = CWRADDR_R[GenAw-1:0];
  assign rd_idx    = CRDADDR[GenAw-1:0];

  // A GEN strobe shadows a simultaneous CON strobe; out-of-range GEN writes are dropped.
  assign gen_wr    = CWRGEN_R && wr_in_rng;
  assign con_wr    = CWRCON_R && !CWRGEN_R;
  assign wr_status = con_wr && (CWRADDR_R == CStatus);
  assign wr_cmd    = con_wr && (CWRADDR_R == CCmd);
  assign wr_opa    = con_wr && (CWRADDR_R == COpa);
  assign wr_opb    = con_wr && (CWRADDR_R == COpb);
  assign start_req = wr_cmd && CWRDATA_R[0];

`ifdef COP_SIGNED_MUL_EN
  assign signed_sel = CWRDATA_R[1];
`else
  assign signed_sel = 1'b0;
`endif

  // ---------------------------------------------------------------------------------------------
  // Multiplier datapath: one shift-add step per cycle
  // ---------------------------------------------------------------------------------------------
  logic [32:0] sum33;
  logic [63:0] acc_step;
  logic [63:0] prod_final;
  logic        a_neg, b_neg;

  // Add the multiplicand into the upper half when the multiplier LSB is set, then shift right.
  always_comb begin
    sum33      = {1'b0, acc_q[63:32]} + (mplier_q[0] ? {1'b0, mcand_q} : 33'd0);
    acc_step   = {sum33, acc_q[31:1]};
    prod_final = neg_q ? (~acc_step + 64'd1) : acc_step;
  end

  assign a_neg = signed_sel && opa_q[31];
  assign b_neg = signed_sel && opb_q[31];

  // Sequencer, status flags, result registers and operand latches.
  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    rlo_d    = rlo_q;
    rhi_d    = rhi_q;
    done_d   = done_q;
    err_d    = err_q;
    opa_d    = wr_opa ? CWRDATA_R : opa_q;
    opb_d    = wr_opb ? CWRDATA_R : opb_q;

    if (wr_status) begin
      if (CWRDATA_R[1]) done_d = 1'b0;
      if (CWRDATA_R[2]) err_d  = 1'b0;
    end

    // Completion is evaluated after W1C so it wins on a coincident edge.
    if (st_q == StRun) begin
      acc_d    = acc_step;
      mplier_d = {1'b0, mplier_q[31:1]};
      cnt_d    = cnt_q + 5'd1;
      if (cnt_q == LastIter) begin
        st_d           = StIdle;
        {rhi_d, rlo_d} = prod_final;
        done_d         = 1'b1;
      end
    end

    if (start_req) begin
      if (st_q == StRun) begin
        err_d = 1'b1;  // sticky; the running op continues untouched
      end else begin
        st_d     = StRun;
        mcand_d  = a_neg ? (~opa_q + 32'd1) : opa_q;
        mplier_d = b_neg ? (~opb_q + 32'd1) : opb_q;
        neg_d    = a_neg ^ b_neg;
        acc_d    = '0;
        cnt_d    = '0;
        done_d   = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------------------------
  logic [31:0] gen_rd_val, con_rd_val;

  // Select read data; a same-edge write that actually lands is forwarded.
  always_comb begin
    gen_rd_val = rd_in_rng ? gen_q[rd_idx] : 32'd0;
    if (gen_wr && (CWRADDR_R == CRDADDR)) gen_rd_val = CWRDATA_R;

    case (CRDADDR)
      CStatus: con_rd_val = {29'd0, err_q, done_q, busy};
      COpa:    con_rd_val = opa_q;
      COpb:    con_rd_val = opb_q;
      CRlo:    con_rd_val = rlo_q;
      CRhi:    con_rd_val = rhi_q;
      default: con_rd_val = 32'd0;
    endcase
    // Only OPA/OPB take a plain write, so only they can be forwarded.
    if ((wr_opa || wr_opb) && (CWRADDR_R == CRDADDR)) con_rd_val = CWRDATA_R;

    rdata_d = rdata_q;
    if (!RHOLD) begin
      if (CRDGEN)      rdata_d = gen_rd_val;
      else if (CRDCON) rdata_d = con_rd_val;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------------------------

  // General register file.
  always_ff @(posedge SYSCLK) begin
    if (!RESET_D1_R_N) begin
      for (int unsigned i = 0; i < NGEN; i++) gen_q[i] <= '0;
    end else if (gen_wr) begin
      gen_q[wr_idx] <= CWRDATA_R;
    end
  end

  // Control bank, multiplier state and read-data register.
  always_ff @(posedge SYSCLK) begin
    if (!RESET_D1_R_N) begin
      rdata_q  <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      rlo_q    <= '0;
      rhi_q    <= '0;
      st_q     <= StIdle;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      rlo_q    <= rlo_d;
      rhi_q    <= rhi_d;
      st_q     <= st_d;
      done_q   <= done_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
    end
  end

  assign CRDDATA = rdata_q;
  assign BUSY    = busy;
  assign CONDINN = ~done_q;

endmodule

// File: tb/tb_cop_mul_responder.sv
// Self-checking bench for cop_mul_responder: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
// Honours COP_SIGNED_MUL_EN the same way as the design.

module tb_cop_mul_responder;

  logic        SYSCLK = 1'b0;
  logic        RESET_D1_R_N = 1'b0;
  logic        RHOLD = 1'b0;
  logic [4:0]  CRDADDR = '0;
  logic        CRDGEN = 1'b0;
  logic        CRDCON = 1'b0;
  logic [31:0] CRDDATA;
  logic [4:0]  CWRADDR_R = '0;
  logic        CWRGEN_R = 1'b0;
  logic        CWRCON_R = 1'b0;
  logic [31:0] CWRDATA_R = '0;
  logic        CONDINN;
  logic        BUSY;

  cop_mul_responder dut (
    .SYSCLK      (SYSCLK),
    .RESET_D1_R_N(RESET_D1_R_N),
    .RHOLD       (RHOLD),
    .CRDADDR     (CRDADDR),
    .CRDGEN      (CRDGEN),
    .CRDCON      (CRDCON),
    .CRDDATA     (CRDDATA),
    .CWRADDR_R   (CWRADDR_R),
    .CWRGEN_R    (CWRGEN_R),
    .CWRCON_R    (CWRCON_R),
    .CWRDATA_R   (CWRDATA_R),
    .CONDINN     (CONDINN),
    .BUSY        (BUSY)
  );

  always #5 SYSCLK = ~SYSCLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------------------------
  // Behavioural model: a multiply is a 64-bit product that appears 32 edges after the start.
  // ---------------------------------------------------------------------------------------------
  logic [31:0] m_gen [32];
  logic [31:0] m_opa, m_opb, m_rlo, m_rhi, m_rd;
  logic [63:0] m_prod;
  bit          m_busy, m_done, m_err, m_valid, was_busy, done_set;
  int          m_left;
`ifdef COP_SIGNED_MUL_EN
  logic signed [63:0] sa, sb;
`endif

  always @(posedge SYSCLK) begin
    if (!RESET_D1_R_N) begin
      foreach (m_gen[i]) m_gen[i] = '0;
      m_opa = '0; m_opb = '0; m_rlo = '0; m_rhi = '0; m_rd = '0;
      m_busy = 0; m_done = 0; m_err = 0; m_left = 0;
      m_valid = 1;
    end else begin
      if (!RHOLD) begin
        if (CRDGEN) begin
          m_rd = (CWRGEN_R && CWRADDR_R == CRDADDR) ? CWRDATA_R : m_gen[CRDADDR];
        end else if (CRDCON) begin
          if (CWRCON_R && !CWRGEN_R && CWRADDR_R == CRDADDR && (CRDADDR == 2 || CRDADDR == 3))
            m_rd = CWRDATA_R;
          else
            case (CRDADDR)
              5'd0:    m_rd = {29'd0, m_err, m_done, m_busy};
              5'd2:    m_rd = m_opa;
              5'd3:    m_rd = m_opb;
              5'd4:    m_rd = m_rlo;
              5'd5:    m_rd = m_rhi;
              default: m_rd = '0;
            endcase
        end
      end
      was_busy = m_busy;
      done_set = 0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          {m_rhi, m_rlo} = m_prod;
          m_busy = 0; m_done = 1; done_set = 1;
        end
      end
      if (CWRGEN_R) begin
        m_gen[CWRADDR_R] = CWRDATA_R;
      end else if (CWRCON_R) begin
        case (CWRADDR_R)
          5'd0: begin
            if (CWRDATA_R[1] && !done_set) m_done = 0;
            if (CWRDATA_R[2]) m_err = 0;
          end
          5'd1: if (CWRDATA_R[0]) begin
            if (was_busy) m_err = 1;
            else begin
`ifdef COP_SIGNED_MUL_EN
              sa = {{32{m_opa[31]}}, m_opa};
              sb = {{32{m_opb[31]}}, m_opb};
              m_prod = CWRDATA_R[1] ? 64'(sa * sb) : {32'd0, m_opa} * {32'd0, m_opb};
`else
              m_prod = {32'd0, m_opa} * {32'd0, m_opb};
`endif
              m_left = 32; m_busy = 1; m_done = 0;
            end
          end
          5'd2: m_opa = CWRDATA_R;
          5'd3: m_opb = CWRDATA_R;
          default: ;
        endcase
      end
    end
  end

  // Compare every cycle, half a period away from the active edge.
  always @(negedge SYSCLK) begin
    if (m_valid) begin
      check("crddata", CRDDATA, m_rd);
      check("busy", {31'd0, BUSY}, {31'd0, m_busy});
      check("condinn", {31'd0, CONDINN}, {31'd0, !m_done});
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------------------------
  task automatic tick();
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic clear_inputs();
    RHOLD = 0; CRDGEN = 0; CRDCON = 0; CWRGEN_R = 0; CWRCON_R = 0;
  endtask

  task automatic write_con(input logic [4:0] a, input logic [31:0] d);
    CWRCON_R = 1; CWRADDR_R = a; CWRDATA_R = d;
    tick();
    CWRCON_R = 0;
  endtask

  task automatic read_con(input logic [4:0] a, input string name, input logic [31:0] exp);
    CRDCON = 1; CRDADDR = a;
    tick();
    CRDCON = 0;
    check(name, CRDDATA, exp);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && BUSY; i++) tick();
    check("busy_timeout", {31'd0, BUSY}, 32'd0);
  endtask

  logic [31:0] exp_lo, exp_hi;
  int          r;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and first read
    RESET_D1_R_N = 0;
    tick(); tick();
    RESET_D1_R_N = 1;
    CRDGEN = 1; CRDADDR = 5'd7;
    tick();
    CRDGEN = 0;
    check("rst_crddata", CRDDATA, 32'd0);
    check("rst_condinn", {31'd0, CONDINN}, 32'd1);
    check("rst_busy", {31'd0, BUSY}, 32'd0);

    // Write/read bypass, then RHOLD freezes the read register
    CWRGEN_R = 1; CWRADDR_R = 5'd5; CWRDATA_R = 32'hDEADBEEF;
    CRDGEN = 1; CRDADDR = 5'd5;
    tick();
    CWRGEN_R = 0;
    check("bypass", CRDDATA, 32'hDEADBEEF);
    RHOLD = 1; CRDADDR = 5'd7;
    tick();
    check("rhold", CRDDATA, 32'hDEADBEEF);
    clear_inputs();

    // Full-scale unsigned multiply
    write_con(5'd2, 32'hFFFFFFFF);
    write_con(5'd3, 32'hFFFFFFFF);
    write_con(5'd1, 32'd1);
    check("busy_after_start", {31'd0, BUSY}, 32'd1);
    for (int i = 0; i < 31; i++) tick();
    check("busy_edge31", {31'd0, BUSY}, 32'd1);
    tick();
    check("busy_edge32", {31'd0, BUSY}, 32'd0);
    check("condinn_done", {31'd0, CONDINN}, 32'd0);
    read_con(5'd4, "rlo_ff", 32'h00000001);
    read_con(5'd5, "rhi_ff", 32'hFFFFFFFE);

    // Start while busy sets err; operand writes do not disturb the running op
    write_con(5'd2, 32'd5);
    write_con(5'd3, 32'd6);
    write_con(5'd1, 32'd1);
    for (int i = 0; i < 9; i++) tick();
    write_con(5'd1, 32'd1);
    write_con(5'd2, 32'd100);
    read_con(5'd0, "status_err", 32'h5);
    read_con(5'd4, "rlo_held", 32'h00000001);
    wait_idle();
    read_con(5'd4, "rlo_5x6", 32'd30);
    read_con(5'd5, "rhi_5x6", 32'd0);
    write_con(5'd0, 32'h6);
    read_con(5'd0, "status_w1c", 32'd0);
    check("condinn_w1c", {31'd0, CONDINN}, 32'd1);

    // Reset in the middle of a multiply
    write_con(5'd1, 32'd1);
    for (int i = 0; i < 15; i++) tick();
    RESET_D1_R_N = 0;
    tick();
    RESET_D1_R_N = 1;
    check("midrst_busy", {31'd0, BUSY}, 32'd0);
    check("midrst_condinn", {31'd0, CONDINN}, 32'd1);
    read_con(5'd4, "midrst_rlo", 32'd0);
    read_con(5'd5, "midrst_rhi", 32'd0);
    read_con(5'd0, "midrst_status", 32'd0);

    // -3 * 7 with the signed command bit
`ifdef COP_SIGNED_MUL_EN
    exp_lo = 32'hFFFFFFEB; exp_hi = 32'hFFFFFFFF;
`else
    exp_lo = 32'hFFFFFFEB; exp_hi = 32'h00000006;
`endif
    write_con(5'd2, 32'hFFFFFFFD);
    write_con(5'd3, 32'd7);
    write_con(5'd1, 32'd3);
    wait_idle();
    read_con(5'd4, "rlo_m3x7", exp_lo);
    read_con(5'd5, "rhi_m3x7", exp_hi);

    // Both strobes: only the GEN write lands
    CWRGEN_R = 1; CWRCON_R = 1; CWRADDR_R = 5'd2; CWRDATA_R = 32'h12345678;
    tick();
    CWRGEN_R = 0; CWRCON_R = 0;
    read_con(5'd2, "both_opa", 32'hFFFFFFFD);
    CRDGEN = 1; CRDADDR = 5'd2;
    tick();
    CRDGEN = 0;
    check("both_gen", CRDDATA, 32'h12345678);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      RESET_D1_R_N = ($urandom_range(0, 999) != 0);
      RHOLD  = ($urandom_range(0, 4) == 0);
      CRDGEN = ($urandom_range(0, 2) == 0);
      CRDCON = ($urandom_range(0, 1) == 0);
      CRDADDR = (CRDCON && !CRDGEN) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      CWRGEN_R = 0; CWRCON_R = 0;
      CWRDATA_R = $urandom;
      r = $urandom_range(0, 99);
      if (r < 30) begin
        CWRGEN_R = 1;
        CWRADDR_R = $urandom_range(0, 1) ? CRDADDR : 5'($urandom);
      end else if (r < 42) begin
        CWRCON_R = 1; CWRADDR_R = 5'($urandom_range(2, 3));
        if ($urandom_range(0, 3) == 0) CWRDATA_R = 32'h80000000 | 32'($urandom_range(0, 5));
      end else if (r < 47) begin
        CWRCON_R = 1; CWRADDR_R = 5'd1;
        CWRDATA_R = {30'($urandom), 1'($urandom), ($urandom_range(0, 5) != 0)};
      end else if (r < 50) begin
        CWRCON_R = 1; CWRADDR_R = 5'd0;
      end
      if (CWRCON_R && CRDCON && !CRDGEN && CRDADDR == CWRADDR_R && CWRADDR_R < 5'd2)
        CRDADDR = 5'd4;
      tick();
    end
    RESET_D1_R_N = 1;
    clear_inputs();
    for (int i = 0; i < 40; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
